// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode encoding, addressing modes and status bit layout.
// Used by the fetch stage and the control FSM.
package sisc_pkg;

  localparam logic [3:0] NOOP   = 4'd0;
  localparam logic [3:0] LOD    = 4'd1;
  localparam logic [3:0] STR    = 4'd2;
  localparam logic [3:0] SWP    = 4'd3;
  localparam logic [3:0] BRA    = 4'd4;
  localparam logic [3:0] BRR    = 4'd5;
  localparam logic [3:0] BNE    = 4'd6;
  localparam logic [3:0] BNR    = 4'd7;
  localparam logic [3:0] ALU_OP = 4'd8;
  localparam logic [3:0] HLT    = 4'd15;

  localparam logic [3:0] am_imm = 4'd8;

  // Status register bit positions, {C,N,V,Z}
  localparam int STAT_C = 3;
  localparam int STAT_N = 2;
  localparam int STAT_V = 1;
  localparam int STAT_Z = 0;

  function automatic logic is_rel_branch(input logic [3:0] op);
    return (op == BRR) || (op == BNR);
  endfunction

endpackage

// File: rtl/sisc_fetch_br_cond.sv
// Branch condition evaluation: mm selects status bits; BRA/BRR take on any hit
// (or unconditionally with mm==0), BNE/BNR take when a non-empty mask sees no hit.
module br_cond
  import sisc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  output logic       taken
);

  logic hit;
  assign hit = |(mm & stat);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      BRA, BRR: taken = (mm == 4'd0) || hit;
      BNE, BNR: taken = (mm != 4'd0) && !hit;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sisc_fetch.sv
// SISC fetch/branch stage: PC, IR and status registers with PC increment and
// branch-target resolution under control-FSM strobes.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int IR_W = 32
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            pc_rst,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            ir_load,
  input  logic [IR_W-1:0] im_data,
  input  logic            stat_en,
  input  logic [3:0]      cc_in,
  output logic [PC_W-1:0] pc_out,
  output logic [IR_W-1:0] ir,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic [15:0]     imm,
  output logic [3:0]      stat,
  output logic            br_taken
);

  logic [PC_W-1:0] pc_q;
  logic [IR_W-1:0] ir_q;
  logic [3:0]      stat_q;
  logic [PC_W-1:0] target;

  assign pc_out = pc_q;
  assign ir     = ir_q;
  assign stat   = stat_q;
  assign opcode = ir_q[31:28];
  assign mm     = ir_q[27:24];
  assign imm    = ir_q[15:0];

  br_cond u_br_cond (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat_q),
    .taken  (br_taken)
  );

  // Relative offsets apply to the already-advanced PC, wrapping mod 2^PC_W
  always_comb begin
    target = PC_W'(imm);
    if (is_rel_branch(opcode))
      target = pc_q + PC_W'($signed(imm));
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)
      pc_q <= '0;
    else if (pc_rst)
      pc_q <= '0;
    else if (pc_write && !pc_sel)
      pc_q <= pc_q + PC_W'(1);
    else if (pc_write && br_taken)
      pc_q <= target;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)
      ir_q <= '0;
    else if (ir_load)
      ir_q <= im_data;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)
      stat_q <= '0;
    else if (stat_en)
      stat_q <= cc_in;
  end

endmodule

// File: tb/tb_sisc_fetch.sv
// Self-checking bench for sisc_fetch: directed scenarios plus randomized strobes
// against an instruction-level model of PC/IR/status behaviour.
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic        pc_rst = 1'b0, pc_write = 1'b0, pc_sel = 1'b0;
  logic        ir_load = 1'b0, stat_en = 1'b0;
  logic [31:0] im_data = '0;
  logic [3:0]  cc_in = '0;
  logic [15:0] pc_out;
  logic [31:0] ir;
  logic [3:0]  opcode, mm, stat;
  logic [15:0] imm;
  logic        br_taken;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc;
  logic [31:0] m_ir;
  logic [3:0]  m_stat;

  always #5 clk = ~clk;

  sisc_fetch #(.PC_W(16), .IR_W(32)) dut (
    .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
    .ir_load(ir_load), .im_data(im_data), .stat_en(stat_en), .cc_in(cc_in),
    .pc_out(pc_out), .ir(ir), .opcode(opcode), .mm(mm), .imm(imm), .stat(stat),
    .br_taken(br_taken)
  );

  function automatic logic m_taken(input logic [31:0] i, input logic [3:0] s);
    int op;
    logic [3:0] msk;
    op = int'(i[31:28]);
    msk = i[27:24];
    if (op == 4 || op == 5) return (msk == 0) || ((msk & s) != 0);
    if (op == 6 || op == 7) return (msk != 0) && ((msk & s) == 0);
    return 1'b0;
  endfunction

  // Advance the model by one edge from the current inputs, clock, then clear strobes.
  task automatic tick();
    logic [15:0] npc;
    logic [31:0] nir;
    logic [3:0]  nstat;
    int op;
    npc = m_pc; nir = m_ir; nstat = m_stat;
    op = int'(m_ir[31:28]);
    if (pc_rst) npc = 16'h0;
    else if (pc_write && !pc_sel) npc = m_pc + 16'd1;
    else if (pc_write && m_taken(m_ir, m_stat)) begin
      if (op == 5 || op == 7) npc = m_pc + m_ir[15:0];
      else npc = m_ir[15:0];
    end
    if (ir_load) nir = im_data;
    if (stat_en) nstat = cc_in;
    @(posedge clk); #1;
    m_pc = npc; m_ir = nir; m_stat = nstat;
    pc_rst = 0; pc_write = 0; pc_sel = 0; ir_load = 0; stat_en = 0;
  endtask

  task automatic load_ir(input logic [31:0] v);
    im_data = v; ir_load = 1; tick();
  endtask

  task automatic load_stat(input logic [3:0] v);
    cc_in = v; stat_en = 1; tick();
  endtask

  // Reach an arbitrary PC through an unconditional absolute branch.
  task automatic set_pc(input logic [15:0] v);
    pc_rst = 1; tick();
    load_ir({8'h40, 8'h00, v});
    pc_write = 1; pc_sel = 1; tick();
  endtask

  task automatic test_reset();
    rst_f = 1; #2; rst_f = 0; #1;
    m_pc = 0; m_ir = 0; m_stat = 0;
    checks++;
    if (pc_out !== 16'h0 || ir !== 32'h0 || stat !== 4'h0 || br_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h ir=%h stat=%b taken=%b, want all zero", pc_out, ir, stat, br_taken);
    end
    im_data = 32'hFFFF_FFFF; ir_load = 1; pc_write = 1; stat_en = 1; cc_in = 4'hF;
    @(posedge clk); #1;
    checks++;
    if (ir !== 32'h0 || pc_out !== 16'h0 || stat !== 4'h0) begin
      errors++;
      $display("FAIL reset_hold: pc=%h ir=%h stat=%b, want all zero", pc_out, ir, stat);
    end
    @(negedge clk); rst_f = 1;
    pc_rst = 0; pc_write = 0; pc_sel = 0; ir_load = 0; stat_en = 0; im_data = 0; cc_in = 0;
  endtask

  task automatic test_increment();
    for (int k = 1; k <= 3; k++) begin
      pc_write = 1; pc_sel = 0; tick();
      checks++;
      if (pc_out !== 16'(k) || pc_out !== m_pc) begin
        errors++;
        $display("FAIL increment_%0d: pc=%h want %h", k, pc_out, 16'(k));
      end
    end
  endtask

  task automatic test_fetch();
    set_pc(16'h0005);
    im_data = 32'h4100_0020; ir_load = 1; pc_write = 1; pc_sel = 0; tick();
    checks++;
    if (opcode !== 4'h4 || mm !== 4'h1 || imm !== 16'h0020 || pc_out !== 16'h0006) begin
      errors++;
      $display("FAIL fetch: op=%h mm=%h imm=%h pc=%h want 4 1 0020 0006", opcode, mm, imm, pc_out);
    end
  endtask

  task automatic test_bra_masked();
    load_stat(4'b0001);
    set_pc(16'h0100);
    load_ir(32'h4100_0040);
    pc_write = 1; pc_sel = 1; tick();
    checks++;
    if (pc_out !== 16'h0040) begin
      errors++;
      $display("FAIL bra_taken: pc=%h want 0040", pc_out);
    end
    load_stat(4'b0000);
    set_pc(16'h0100);
    load_ir(32'h4100_0040);
    checks++;
    if (br_taken !== 1'b0) begin
      errors++;
      $display("FAIL bra_flag_clear: taken=%b want 0", br_taken);
    end
    pc_write = 1; pc_sel = 1; tick();
    checks++;
    if (pc_out !== 16'h0100) begin
      errors++;
      $display("FAIL bra_not_taken: pc=%h want 0100", pc_out);
    end
  endtask

  task automatic test_bnr();
    logic [15:0] start [2];
    logic [15:0] want  [2];
    start[0] = 16'h0010; want[0] = 16'h000C;
    start[1] = 16'h0002; want[1] = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      load_stat(4'b0000);
      set_pc(start[k]);
      load_ir(32'h7400_FFFC);
      checks++;
      if (br_taken !== 1'b1) begin
        errors++;
        $display("FAIL bnr_flag_%0d: taken=%b want 1", k, br_taken);
      end
      pc_write = 1; pc_sel = 1; tick();
      checks++;
      if (pc_out !== want[k]) begin
        errors++;
        $display("FAIL bnr_target_%0d: pc=%h want %h", k, pc_out, want[k]);
      end
    end
  endtask

  task automatic test_simultaneous();
    load_stat(4'b0000);
    set_pc(16'h0020);
    load_ir(32'h4100_0040);
    stat_en = 1; cc_in = 4'b0001; pc_write = 1; pc_sel = 1; tick();
    checks++;
    if (pc_out !== 16'h0020 || stat !== 4'b0001) begin
      errors++;
      $display("FAIL stat_race: pc=%h stat=%b want 0020 0001", pc_out, stat);
    end
    checks++;
    if (br_taken !== 1'b1) begin
      errors++;
      $display("FAIL stat_race_after: taken=%b want 1", br_taken);
    end
    pc_rst = 1; pc_write = 1; pc_sel = 0; tick();
    checks++;
    if (pc_out !== 16'h0000) begin
      errors++;
      $display("FAIL pc_rst_priority: pc=%h want 0000", pc_out);
    end
  endtask

  task automatic test_wrap();
    set_pc(16'hFFFF);
    pc_write = 1; pc_sel = 0; tick();
    checks++;
    if (pc_out !== 16'h0000) begin
      errors++;
      $display("FAIL inc_wrap: pc=%h want 0000", pc_out);
    end
    load_ir(32'h8000_1234);
    pc_write = 1; pc_sel = 1; tick();
    checks++;
    if (pc_out !== 16'h0000) begin
      errors++;
      $display("FAIL nonbranch_hold: pc=%h want 0000", pc_out);
    end
  endtask

  task automatic test_async_reset();
    set_pc(16'h1234);
    load_stat(4'b1010);
    load_ir(32'h5F00_0003);
    @(posedge clk); #3;
    rst_f = 0; #1;
    checks++;
    if (pc_out !== 16'h0 || ir !== 32'h0 || stat !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: pc=%h ir=%h stat=%b want all zero", pc_out, ir, stat);
    end
    @(negedge clk); rst_f = 1;
    m_pc = 0; m_ir = 0; m_stat = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      pc_rst   = ($urandom_range(0, 15) == 0);
      pc_write = 1'($urandom_range(0, 1));
      pc_sel   = 1'($urandom_range(0, 1));
      ir_load  = ($urandom_range(0, 2) == 0);
      stat_en  = ($urandom_range(0, 2) == 0);
      cc_in    = 4'($urandom);
      im_data  = {4'($urandom_range(0, 9)), ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom), 24'($urandom)};
      tick();
      checks++;
      if (pc_out !== m_pc || ir !== m_ir || stat !== m_stat || br_taken !== m_taken(m_ir, m_stat) ||
          opcode !== m_ir[31:28] || mm !== m_ir[27:24] || imm !== m_ir[15:0]) begin
        errors++;
        $display("FAIL random_%0d: pc=%h ir=%h stat=%b taken=%b want pc=%h ir=%h stat=%b taken=%b",
                 n, pc_out, ir, stat, br_taken, m_pc, m_ir, m_stat, m_taken(m_ir, m_stat));
      end
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_fetch();
    test_bra_masked();
    test_bnr();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sisc_fetch.md
# sisc_fetch

Instruction-fetch and branch stage of the SISC processor. Holds the program counter (PC), the instruction register (IR) and the 4-bit status register. Supplies instruction-memory addresses, and feeds `opcode`, `mm` and `stat` directly into the control FSM. Applies PC-increment, branch-target and condition-mask resolution under the strobes the FSM generates.

## Interface

Parameters:
- `PC_W`, 16: PC and instruction-memory address width.
- `IR_W`, 32: instruction width; fixed at 32 for the SISC encoding.

Ports (reset `rst_f`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_f`  in  1  asynchronous active-low reset.
- `pc_rst`  in  1  synchronous PC clear, from ctrl (start1).
- `pc_write`  in  1  PC update enable, from ctrl.
- `pc_sel`  in  1  0 = PC+1 (fetch); 1 = branch target if taken (execute).
- `ir_load`  in  1  latch `im_data` into IR.
- `im_data`  in  IR_W  instruction-memory read data.
- `stat_en`  in  1  load status register.
- `cc_in`  in  4  new condition codes {C,N,V,Z} from the ALU.
- `pc_out`  out  PC_W  current PC; drives instruction-memory address.
- `ir`  out  IR_W  current instruction.
- `opcode`  out  4  `ir[31:28]`.
- `mm`  out  4  `ir[27:24]`; mode/mask field.
- `imm`  out  16  `ir[15:0]`.
- `stat`  out  4  registered status {C,N,V,Z}.
- `br_taken`  out  1  branch condition true for current IR.

## Operation

- Reset (`rst_f` low): `pc_out`=0, `ir`=0 (decodes as NOOP), `stat`=0. All outputs are registered or decoded from registers, so all derived outputs are 0.
- PC update priority per edge:
  - `pc_rst` gives PC=0.
  - Otherwise, `pc_write & ~pc_sel` gives PC+1.
  - Otherwise, `pc_write & pc_sel & br_taken` gives the branch target.
  - Otherwise, PC holds.
- Branch target, mod 2^PC_W:
  - BRA(4) and BNE(6): absolute, PC = `imm`.
  - BRR(5) and BNR(7): relative, PC = PC + sign-extended `imm`. PC already points past the branch, so the offset is relative to the next instruction.
- `br_taken`, combinational from `ir` and registered `stat`:
  - BRA/BRR: 1 if `mm`==0 (unconditional) or `(mm & stat)` != 0.
  - BNE/BNR: 1 if `mm`!=0 and `(mm & stat)`==0.
  - All other opcodes: 0.
  - A `pc_sel`=1 write with a non-branch opcode holds PC.
- IR: loads `im_data` when `ir_load`, else holds. `opcode`, `mm` and `imm` are pure slices of `ir`.
- Status: loads `cc_in` when `stat_en`, else holds.

## Timing

- All registers are single-cycle: a strobe at edge N is visible on outputs after edge N.
- Fetch sequence from ctrl: `ir_load` and `pc_write` with `pc_sel`=0 on the same edge. IR captures the instruction at the old PC, and PC advances to PC+1.
- Branch decision uses `stat` as it stood before the edge. A simultaneous `stat_en` affects only later branches.
- `pc_rst` together with `pc_write`: `pc_rst` wins.
- `rst_f` asserted mid-instruction clears all state immediately, independent of `clk`. Release is sampled at the next rising edge.
- Wrap-around: PC+1 from 0xFFFF gives 0x0000. Relative branches wrap modulo 2^16 with no flag.
- `im_data` must be stable at the rising edge where `ir_load`=1. Instruction memory is combinational-read on `pc_out`.

## Structure

- Shared package `sisc_pkg`:
  - Opcode constants (NOOP, LOD, STR, SWP, BRA, BRR, BNE, BNR, ALU_OP, HLT).
  - Addressing-mode constant `am_imm`=8.
  - Status bit indices C=3, N=2, V=1, Z=0.
  - The ctrl FSM uses the same package.
- One sub-module, `br_cond`: combinational taken-logic from opcode, mm and stat. It is verified standalone.
- PC, IR and status registers stay in `sisc_fetch` top.

## Test plan

- Reset and increment: `rst_f` pulse, then 3 edges with `pc_write`=1, `pc_sel`=0 → `pc_out` = 0, 1, 2, 3; `ir`=0 during reset.
- Fetch: `im_data`=0x4100_0020 at PC=5 with `ir_load`=1 → `opcode`=4, `mm`=1, `imm`=0x0020, PC=6.
- BRA masked: `stat`=0001, IR=BRA mm=0001 imm=0x0040, `pc_sel`=1 → PC=0x0040. Repeat with `stat`=0000 → PC holds.
- BNR negative offset: PC=0x0010, IR=BNR mm=0100 imm=0xFFFC, `stat`=0000 → PC=0x000C. Same stimulus with PC=0x0002 → PC=0xFFFE (wrap).
- Simultaneous events:
  - `stat_en` with `cc_in`=0001 on the same edge as a BRA mm=0001 when old `stat`=0000 → not taken, then `stat`=0001.
  - `pc_rst`+`pc_write` → PC=0.
- Async reset mid-run: PC=0x1234 and `stat`=1010, drop `rst_f` between edges → `pc_out`, `ir` and `stat` become 0 before the next edge.
